inst_cache_ctrl: RTL and testbench

INST_CACHE_CTRL -- requirements
Module: inst_cache_ctrl

---
 rtl/icache_pkg.sv | 22 ++
 rtl/config.sv | 12 +
 rtl/inst_cache_sram.sv | 33 +++
 rtl/inst_cache_ctrl.sv | 144 ++++++++++++++
 tb/tb_inst_cache_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction cache: the controller FSM
// state encoding, the address-split widths and the cache-line type.
`include "config.sv"

package icache_pkg;

  localparam int unsigned WORD_W    = `DRAM_WORD_SIZE;
  localparam int unsigned BLK_WORDS = `DRAM_BLOCK_SIZE;
  localparam int unsigned OFS_W     = $clog2(`DRAM_BLOCK_SIZE);
  localparam int unsigned IDX_W     = `ICACHE_INDEX;
  localparam int unsigned LINES     = `ICACHE_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    FILL
  } icache_state_e;

  // One cache line; element [i] is the word at block offset i.
  typedef logic [BLK_WORDS-1:0][WORD_W-1:0] icache_block_t;

endpackage

// File: rtl/config.sv
// Build-wide cache and DRAM geometry. Every RTL file includes this one, and the
// guard below means it is only expanded once.
//   DRAM_WORD_SIZE  : bits per instruction word
//   DRAM_BLOCK_SIZE : words per DRAM block (one cache line)
//   ICACHE_INDEX    : index bits; ICACHE_SIZE = 2**ICACHE_INDEX lines
`ifndef ICACHE_CONFIG_SV
`define ICACHE_CONFIG_SV
`define DRAM_WORD_SIZE  32
`define DRAM_BLOCK_SIZE 4
`define ICACHE_INDEX    4
`define ICACHE_SIZE     (1 << `ICACHE_INDEX)
`endif

// File: rtl/inst_cache_sram.sv
// Data array of the instruction cache: one full block per line.
// The read is asynchronous, so a hit returns data in the request cycle. The
// write stores a whole block on the rising edge. Contents are never reset;
// the valid bits in the controller decide whether they mean anything.
// Ports:
//   clk_i   : clock
//   we_i    : write the block wdata_i into line waddr_i
//   waddr_i : line written
//   wdata_i : block written
//   raddr_i : line read
//   rdata_o : block currently held in line raddr_i
`include "config.sv"

module inst_cache_sram
  import icache_pkg::*;
(
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  icache_block_t wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output icache_block_t rdata_o
);

  icache_block_t mem_q [LINES];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_cache_ctrl.sv
// Direct-mapped, blocking instruction cache controller.
// A hit in IDLE is served in the same cycle. On a miss the controller requests
// the block from DRAM (REFILL) and installs it (FILL). It then returns to IDLE,
// where the request the CPU is still holding hits.
// Optional feature: define ICACHE_PERF_CNT_EN to add the hit_cnt and miss_cnt
// outputs.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   fetch_req, fetch_addr  : CPU fetch (word address), held until fetch_valid
//   fetch_valid, fetch_data: returned instruction word
//   flush                  : one-cycle pulse that invalidates every line
//   mem_req, mem_addr      : block refill request and block-aligned address
//   mem_valid, mem_rdata   : refill response (one whole block)
//   hit_cnt, miss_cnt      : saturating counters (ICACHE_PERF_CNT_EN only)
`include "config.sv"

module inst_cache_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_req,
  input  logic [ADDR_W-1:0]          fetch_addr,
  output logic                       fetch_valid,
  output logic [`DRAM_WORD_SIZE-1:0] fetch_data,
  input  logic                       flush,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_valid,
  input  logic [`DRAM_WORD_SIZE-1:0] mem_rdata [`DRAM_BLOCK_SIZE]
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]                hit_cnt,
  output logic [31:0]                miss_cnt
`endif
);

  localparam int unsigned OFFSET_W = $clog2(`DRAM_BLOCK_SIZE);
  localparam int unsigned TAG_W    = ADDR_W - `ICACHE_INDEX - OFFSET_W;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [OFFSET_W-1:0] req_ofs;

  assign {req_tag, req_idx, req_ofs} = fetch_addr;

  icache_state_e    state_q, state_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] miss_tag_q;
  logic [IDX_W-1:0] miss_idx_q;
  icache_block_t    fill_blk_q;
  icache_block_t    rd_blk;
  logic             hit;
  logic             miss;
  logic             sram_we;

  assign hit     = (state_q == IDLE) && fetch_req && valid_q[req_idx]
                   && (tag_q[req_idx] == req_tag);
  assign miss    = (state_q == IDLE) && fetch_req && !hit;
  assign sram_we = (state_q == FILL);

  assign fetch_valid = hit;
  assign fetch_data  = hit ? rd_blk[req_ofs] : '0;
  assign mem_req     = (state_q == REFILL);
  assign mem_addr    = mem_req ? {miss_tag_q, miss_idx_q, {OFFSET_W{1'b0}}} : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss) state_d = REFILL;
      REFILL:  if (mem_valid) state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The tag and index of the miss are latched so the refill and the install
  // do not depend on fetch_addr after the miss is detected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      fill_blk_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss) begin
        miss_tag_q <= req_tag;
        miss_idx_q <= req_idx;
      end
      if ((state_q == REFILL) && mem_valid) begin
        for (int unsigned w = 0; w < BLK_WORDS; w++) fill_blk_q[w] <= mem_rdata[w];
      end
      // The install comes after the flush, so a fill wins over a coincident
      // flush for its own line.
      if (flush) valid_q <= '0;
      if (sram_we) valid_q[miss_idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (sram_we) tag_q[miss_idx_q] <= miss_tag_q;
  end

  inst_cache_sram u_sram (
    .clk_i   (clk),
    .we_i    (sram_we),
    .waddr_i (miss_idx_q),
    .wdata_i (fill_blk_q),
    .raddr_i (req_idx),
    .rdata_o (rd_blk)
  );

`ifdef ICACHE_PERF_CNT_EN
  logic        fill_done_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // The hit that follows a FILL serves the refilled request, so it is not
  // counted as a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_done_q <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      fill_done_q <= (state_q == FILL);
      if (hit && !fill_done_q && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  // The CPU must hold fetch_addr until the fetch is served.
  a_fetch_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (fetch_req && !fetch_valid) |=> (!fetch_req || $stable(fetch_addr)));

endmodule

// File: tb/tb_inst_cache_ctrl.sv
// Directed bench for inst_cache_ctrl. A DRAM responder inside run_fetch
// returns word A = {16'hA5A5 ^ A, A} for every word address A. The expected
// instruction words below are written out by hand from that rule.
module tb_inst_cache_ctrl;
  import icache_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fetch_req;
  logic [15:0]       fetch_addr;
  logic              fetch_valid;
  logic [WORD_W-1:0] fetch_data;
  logic              flush;
  logic              mem_req;
  logic [15:0]       mem_addr;
  logic              mem_valid;
  logic [WORD_W-1:0] mem_rdata [BLK_WORDS];
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]       hit_cnt, miss_cnt;
`endif

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  inst_cache_ctrl #(.ADDR_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_valid   (mem_valid),
    .mem_rdata   (mem_rdata)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {16'hA5A5 ^ a, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a fetch after the next edge and serves refills. nwait is the
  // number of mem_req cycles before mem_valid. lat counts the cycles from the
  // request to fetch_valid. With flush_fill set, flush is pulsed in the FILL
  // cycle. Returns with fetch_valid high, between edges.
  task automatic run_fetch(input logic [15:0] a, input int unsigned nwait, input bit flush_fill,
                           output int unsigned lat, output int unsigned nreq);
    bit fill_next;
    tick();
    fetch_req = 1'b1;
    fetch_addr = a;
    lat = 0;
    nreq = 0;
    fill_next = 1'b0;
    #1;
    while (!fetch_valid && lat < 40) begin
      if (mem_req) begin
        nreq++;
        check("mem_addr", 32'(mem_addr), 32'({a[15:2], 2'b00}));
        if (nreq == nwait) begin
          mem_valid = 1'b1;
          for (int w = 0; w < BLK_WORDS; w++) mem_rdata[w] = mem_word({a[15:2], 2'(w)});
          fill_next = flush_fill;
        end
      end
      tick();
      mem_valid = 1'b0;
      flush = fill_next;
      fill_next = 1'b0;
      lat++;
      #1;
    end
    check("served", 32'(fetch_valid), 32'd1);
  endtask

  logic [15:0] cf_addr [4];
  logic [31:0] cf_data [4];
  int unsigned lat, nreq;

  initial begin
    cf_addr[0] = 16'h0440; cf_data[0] = 32'hA1E5_0440;
    cf_addr[1] = 16'h0040; cf_data[1] = 32'hA5E5_0040;
    cf_addr[2] = 16'h0443; cf_data[2] = 32'hA1E6_0443;
    cf_addr[3] = 16'h0042; cf_data[3] = 32'hA5E7_0042;

    fetch_req = 1'b0;
    fetch_addr = '0;
    flush = 1'b0;
    mem_valid = 1'b0;
    for (int w = 0; w < BLK_WORDS; w++) mem_rdata[w] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_fetch_data", fetch_data, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
`ifdef ICACHE_PERF_CNT_EN
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    // Cold miss of 0x0040, mem_valid on the third mem_req cycle
    run_fetch(16'h0040, 3, 1'b0, lat, nreq);
    check("cold_lat", lat, 32'd5);
    check("cold_nreq", nreq, 32'd3);
    check("cold_data", fetch_data, 32'hA5E5_0040);
`ifdef ICACHE_PERF_CNT_EN
    check("cold_miss_cnt", miss_cnt, 32'd1);
    check("cold_hit_cnt", hit_cnt, 32'd0);
`endif

    // A stray mem_valid in IDLE has no effect
    tick();
    fetch_req = 1'b0;
    mem_valid = 1'b1;
    for (int w = 0; w < BLK_WORDS; w++) mem_rdata[w] = 32'hDEAD_BEEF;
    tick();
    mem_valid = 1'b0;
    check("stray_mem_req", 32'(mem_req), 32'd0);

    // Zero-wait hit on 0x0041
    run_fetch(16'h0041, 1, 1'b0, lat, nreq);
    check("hit_lat", lat, 32'd0);
    check("hit_nreq", nreq, 32'd0);
    check("hit_data", fetch_data, 32'hA5E4_0041);

    // A request held high is served again every cycle
    tick();
    check("hold1_valid", 32'(fetch_valid), 32'd1);
    check("hold1_data", fetch_data, 32'hA5E4_0041);
`ifdef ICACHE_PERF_CNT_EN
    check("hold1_hit_cnt", hit_cnt, 32'd1);
`endif
    tick();
    check("hold2_valid", 32'(fetch_valid), 32'd1);
`ifdef ICACHE_PERF_CNT_EN
    check("hold2_hit_cnt", hit_cnt, 32'd2);
`endif

    // Same index, alternating tags: every access replaces line 0
    for (int i = 0; i < 4; i++) begin
      run_fetch(cf_addr[i], i + 1, 1'b0, lat, nreq);
      check($sformatf("conf%0d_lat", i), lat, 32'(i + 3));
      check($sformatf("conf%0d_nreq", i), nreq, 32'(i + 1));
      check($sformatf("conf%0d_data", i), fetch_data, cf_data[i]);
    end
`ifdef ICACHE_PERF_CNT_EN
    check("conf_miss_cnt", miss_cnt, 32'd5);
    check("conf_hit_cnt", hit_cnt, 32'd3);
`endif

    // Hit and flush in the same cycle: the hit still returns the old line
    tick();
    fetch_addr = 16'h0043;
    flush = 1'b1;
    #1;
    check("hitflush_valid", 32'(fetch_valid), 32'd1);
    check("hitflush_data", fetch_data, 32'hA5E6_0043);
    tick();
    flush = 1'b0;
    fetch_req = 1'b0;

    // Refetch after the flush misses again
    run_fetch(16'h0040, 1, 1'b0, lat, nreq);
    check("reflush_lat", lat, 32'd3);
    check("reflush_nreq", nreq, 32'd1);
    check("reflush_data", fetch_data, 32'hA5E5_0040);

    // Flush in the FILL cycle: the filled line survives, line 0 does not
    run_fetch(16'h0044, 2, 1'b1, lat, nreq);
    check("fillflush_lat", lat, 32'd4);
    check("fillflush_data", fetch_data, 32'hA5E1_0044);
    run_fetch(16'h0045, 1, 1'b0, lat, nreq);
    check("fillflush_hit_lat", lat, 32'd0);
    check("fillflush_hit_data", fetch_data, 32'hA5E0_0045);
    run_fetch(16'h0040, 1, 1'b0, lat, nreq);
    check("fillflush_other_nreq", nreq, 32'd1);
    check("fillflush_other_data", fetch_data, 32'hA5E5_0040);

    // Reset in the middle of a refill
    tick();
    fetch_addr = 16'h0080;
    tick();
    check("rr_mem_req_on", 32'(mem_req), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check("rr_mem_req_off", 32'(mem_req), 32'd0);
    check("rr_mem_addr", 32'(mem_addr), 32'd0);
    tick();
    fetch_req = 1'b0;
    rst_n = 1'b1;
`ifdef ICACHE_PERF_CNT_EN
    check("rr_miss_cnt", miss_cnt, 32'd0);
    check("rr_hit_cnt", hit_cnt, 32'd0);
`endif
    run_fetch(16'h0040, 2, 1'b0, lat, nreq);
    check("rr_refetch_lat", lat, 32'd4);
    check("rr_refetch_nreq", nreq, 32'd2);
    check("rr_refetch_data", fetch_data, 32'hA5E5_0040);

    tick();
    fetch_req = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
